noc_vc_input_port: RTL and testbench

Parametrised NoC router input port with per-virtual-channel flit buffering and credit-based flow control on both sides. Accepts flits from the upstream link into one FIFO per VC and returns one credit upstream per flit drained. Forwards flits downstream through a round-robin VC arbiter gated by per-VC downstream credit counters. Successor of the single-channel 16-bit valid/data/credit router port; it adds VCs, configurable width and depth, and downstream credit tracking.

---
 rtl/noc_vc_input_port.sv | 179 +++++++++++++++++
 tb/tb_noc_vc_input_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_input_port.sv
// noc_vc_input_port
// Router input port with one flit FIFO per virtual channel. Upstream writes
// into FIFO[vc_i]; a round-robin arbiter, gated by per-VC downstream credit
// counters, forwards at most one flit per cycle. Every forwarded flit returns
// one credit upstream on credit_o, in the same cycle as the flit on enable_o.
module noc_vc_input_port #(
  parameter int DATA_W       = 16,
  parameter int NUM_VC       = 2,
  parameter int DEPTH        = 4,
  parameter int DOWN_CREDITS = 4,
  parameter int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [VC_W-1:0]   vc_i,
  input  logic [NUM_VC-1:0] credit_i,
  output logic              enable_o,
  output logic [DATA_W-1:0] data_o,
  output logic [VC_W-1:0]   vc_o,
  output logic [NUM_VC-1:0] credit_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DC_W  = $clog2(DOWN_CREDITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DC_W-1:0]  DC_FULL  = DC_W'(DOWN_CREDITS);
  localparam logic [VC_W-1:0]  VC_LAST  = VC_W'(NUM_VC - 1);

  // Per-VC storage and bookkeeping
  logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  r_count  [NUM_VC];
  logic [DC_W-1:0]   r_dcred  [NUM_VC];

  // Arbiter pointer and registered outputs
  logic [VC_W-1:0]   r_rr_ptr;
  logic              r_enable;
  logic [DATA_W-1:0] r_data;
  logic [VC_W-1:0]   r_vc;
  logic [NUM_VC-1:0] r_credit;
  logic              r_err;

  // Combinational decisions for the current cycle
  logic [NUM_VC-1:0] w_eligible;
  logic              w_grant;
  logic [VC_W-1:0]   w_gnt_vc;
  int                w_idx;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_wr;
  logic [NUM_VC-1:0] w_cred_err;
  logic              w_err_evt;
  logic [DATA_W-1:0] w_head;
  logic [VC_W-1:0]   w_rr_next;

  // A VC may be forwarded when it holds a flit (pre-write count) and has credit
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_eligible[v] = (r_count[v] != '0) && (r_dcred[v] != '0);
    end
  end

  // Round-robin search starting at r_rr_ptr; first eligible VC wins
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a path that skips it infers a latch.
    w_grant  = 1'b0;
    w_gnt_vc = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_VC;
      if (!w_grant && w_eligible[w_idx]) begin
        w_grant  = 1'b1;
        w_gnt_vc = VC_W'(w_idx);
      end
    end
  end

  // Pop strobe, head-of-line flit and the pointer value after a grant
  always_comb begin
    w_pop = '0;
    if (w_grant) begin
      w_pop[w_gnt_vc] = 1'b1;
    end
    w_head    = r_mem[w_gnt_vc][r_rd_ptr[w_gnt_vc]];
    w_rr_next = (w_gnt_vc == VC_LAST) ? '0 : w_gnt_vc + 1'b1;
  end

  // Write acceptance (full FIFO accepts only when it pops this cycle) and errors
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_wr[v]       = valid_i && (vc_i == VC_W'(v)) &&
                      ((r_count[v] != CNT_FULL) || w_pop[v]);
      w_cred_err[v] = credit_i[v] && !w_pop[v] && (r_dcred[v] == DC_FULL);
    end
    // A valid flit that no VC accepted was either full or addressed a bad VC
    w_err_evt = (valid_i && (w_wr == '0)) || (w_cred_err != '0);
  end

  // Flit storage write port
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; occupancy is tracked by the counters,
    // so stale contents are never observed and the array can map to RAM.
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_wr[v]) begin
        r_mem[v][r_wr_ptr[v]] <= data_i;
      end
    end
  end

  // Per-VC FIFO pointers, occupancy and downstream credit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
        r_dcred[v]  <= DC_FULL;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (w_wr[v]) begin
          r_wr_ptr[v] <= r_wr_ptr[v] + 1'b1;
        end
        if (w_pop[v]) begin
          r_rd_ptr[v] <= r_rd_ptr[v] + 1'b1;
        end
        if (w_wr[v] && !w_pop[v]) begin
          r_count[v] <= r_count[v] + 1'b1;
        end else if (!w_wr[v] && w_pop[v]) begin
          r_count[v] <= r_count[v] - 1'b1;
        end
        // Credit return and consumption in the same cycle cancel out
        if (w_pop[v] && !credit_i[v]) begin
          r_dcred[v] <= r_dcred[v] - 1'b1;
        end else if (!w_pop[v] && credit_i[v] && (r_dcred[v] != DC_FULL)) begin
          r_dcred[v] <= r_dcred[v] + 1'b1;
        end
      end
    end
  end

  // Arbiter pointer, downstream flit, upstream credit and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_enable <= 1'b0;
      r_data   <= '0;
      r_vc     <= '0;
      r_credit <= '0;
      r_err    <= 1'b0;
    end else begin
      r_enable <= w_grant;
      r_credit <= w_pop;
      if (w_grant) begin
        r_rr_ptr <= w_rr_next;
        r_data   <= w_head;
        r_vc     <= w_gnt_vc;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign enable_o = r_enable;
  assign data_o   = r_data;
  assign vc_o     = r_vc;
  assign credit_o = r_credit;
  assign err_o    = r_err;

endmodule

// File: tb/tb_noc_vc_input_port.sv
// tb_noc_vc_input_port
// Directed scenarios followed by a randomized run. Expected outputs come from
// a queue-based model of the port: per-VC flit queues, credit counts, a
// round-robin pointer and a sticky error bit, stepped once per clock.
module tb_noc_vc_input_port;

  localparam int DATA_W       = 16;
  localparam int NUM_VC       = 2;
  localparam int DEPTH        = 4;
  localparam int DOWN_CREDITS = 4;
  localparam int VC_W         = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic [VC_W-1:0]   vc_i;
  logic [NUM_VC-1:0] credit_i;
  logic              enable_o;
  logic [DATA_W-1:0] data_o;
  logic [VC_W-1:0]   vc_o;
  logic [NUM_VC-1:0] credit_o;
  logic              err_o;

  noc_vc_input_port #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH),
    .DOWN_CREDITS(DOWN_CREDITS), .VC_W(VC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .data_i(data_i), .vc_i(vc_i), .credit_i(credit_i),
    .enable_o(enable_o), .data_o(data_o), .vc_o(vc_o),
    .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [NUM_VC][$];
  int                m_dcred [NUM_VC];
  int                m_rr;
  logic              m_err;
  logic              m_en;
  logic [DATA_W-1:0] m_data;
  logic [VC_W-1:0]   m_vc;
  logic [NUM_VC-1:0] m_cred;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      mq[v].delete();
      m_dcred[v] = DOWN_CREDITS;
    end
    m_rr   = 0;
    m_err  = 1'b0;
    m_en   = 1'b0;
    m_data = '0;
    m_vc   = '0;
    m_cred = '0;
  endtask

  // One clock of the port's behaviour, evaluated from pre-edge state
  task automatic model_step(input logic v_in, input logic [DATA_W-1:0] d_in,
                            input logic [VC_W-1:0] c_in, input logic [NUM_VC-1:0] cr_in);
    int g;
    int pre_size [NUM_VC];
    g = -1;
    for (int v = 0; v < NUM_VC; v++) pre_size[v] = mq[v].size();
    for (int k = 0; k < NUM_VC; k++) begin
      int v;
      v = (m_rr + k) % NUM_VC;
      if (g < 0 && pre_size[v] > 0 && m_dcred[v] > 0) g = v;
    end
    if (g >= 0) begin
      m_en   = 1'b1;
      m_data = mq[g].pop_front();
      m_vc   = VC_W'(g);
      m_cred = NUM_VC'(1 << g);
      m_dcred[g]--;
      m_rr = (g + 1) % NUM_VC;
    end else begin
      m_en   = 1'b0;
      m_cred = '0;
    end
    if (v_in) begin
      if (int'(c_in) >= NUM_VC) m_err = 1'b1;
      else if (pre_size[c_in] < DEPTH || g == int'(c_in)) mq[c_in].push_back(d_in);
      else m_err = 1'b1;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      if (cr_in[v]) begin
        if (g == v) m_dcred[v]++;
        else if (m_dcred[v] == DOWN_CREDITS) m_err = 1'b1;
        else m_dcred[v]++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".enable"}, 32'(enable_o), 32'(m_en));
    check({tag, ".data"},   32'(data_o),   32'(m_data));
    check({tag, ".vc"},     32'(vc_o),     32'(m_vc));
    check({tag, ".credit"}, 32'(credit_o), 32'(m_cred));
    check({tag, ".err"},    32'(err_o),    32'(m_err));
  endtask

  // Drive one cycle of stimulus, advance the model, check after the edge
  task automatic cycle(input logic v_in, input logic [DATA_W-1:0] d_in,
                       input logic [VC_W-1:0] c_in, input logic [NUM_VC-1:0] cr_in,
                       input string tag);
    valid_i  = v_in;
    data_i   = d_in;
    vc_i     = c_in;
    credit_i = cr_in;
    model_step(v_in, d_in, c_in, cr_in);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, '0, '0, '0, tag);
  endtask

  task automatic do_reset(input string tag);
    valid_i  = 1'b0;
    data_i   = '0;
    vc_i     = '0;
    credit_i = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs({tag, ".release"});
  endtask

  initial begin
    int hi;
    do_reset("reset");

    // Single flit on VC1 appears the cycle after acceptance
    cycle(1'b1, 16'hA5A5, 1'b1, 2'b00, "a5_in");
    check("a5_in.no_bypass", 32'(enable_o), 32'd0);
    idle("a5_out");
    check("a5.enable", 32'(enable_o), 32'd1);
    check("a5.data",   32'(data_o),   32'hA5A5);
    check("a5.vc",     32'(vc_o),     32'd1);
    check("a5.credit", 32'(credit_o), 32'b10);
    idle("a5_after");
    cycle(1'b0, '0, '0, 2'b10, "a5_restore");

    // Four VC0 flits drain back-to-back; the fifth waits for a credit
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h1000 + i), 1'b0, 2'b00, "fill0");
    cycle(1'b1, 16'h1004, 1'b0, 2'b00, "fifth_in");
    for (int i = 0; i < 3; i++) begin
      idle("fifth_wait");
      check("fifth_wait.enable", 32'(enable_o), 32'd0);
    end
    cycle(1'b0, '0, '0, 2'b01, "cred0");
    idle("fifth_out");
    check("fifth.enable", 32'(enable_o), 32'd1);
    check("fifth.data",   32'(data_o),   32'h1004);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 2'b01, "restore0");

    // Alternating writes keep enable_o high for six cycles with VCs alternating
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, DATA_W'(16'h2000 + i), VC_W'(i % 2), 2'b00, "alt");
      if (i > 0) hi += int'(enable_o);
    end
    idle("alt_tail");
    hi += int'(enable_o);
    check("alt.run_len", 32'(hi), 32'd6);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 2'b11, "alt_restore");

    // Overflow of a full VC0 with no pop: dropped, sticky error, contents intact
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h3000 + i), 1'b0, 2'b00, "ovf_drain");
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h3100 + i), 1'b0, 2'b00, "ovf_fill");
    cycle(1'b1, 16'h31FF, 1'b0, 2'b00, "ovf_drop");
    check("ovf.err", 32'(err_o), 32'd1);
    idle("ovf_sticky");
    check("ovf.err_sticky", 32'(err_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 2'b01, "ovf_cred");
      idle("ovf_out");
      check("ovf.contents", 32'(data_o), 32'(16'h3100 + i));
    end

    // Full VC0 written in the same cycle it pops: accepted, no error
    do_reset("reset2");
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h4000 + i), 1'b0, 2'b00, "fp_drain");
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h4100 + i), 1'b0, 2'b00, "fp_fill");
    cycle(1'b0, '0, '0, 2'b01, "fp_cred");
    cycle(1'b1, 16'h41FF, 1'b0, 2'b00, "fp_write");
    check("fp.err", 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 2'b01, "fp_cred2");
      idle("fp_out");
    end
    check("fp.last_flit", 32'(data_o), 32'h41FF);

    // Credit coincident with a VC0 grant leaves the counter at its maximum
    do_reset("reset3");
    cycle(1'b1, 16'h5000, 1'b0, 2'b00, "cg_in");
    cycle(1'b0, '0, '0, 2'b01, "cg_grant");
    check("cg.err", 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(16'h5100 + i), 1'b0, 2'b00, "cg_burst");
    cycle(1'b1, 16'h51FF, 1'b0, 2'b00, "cg_fifth");
    for (int i = 0; i < 3; i++) idle("cg_blocked");
    // Credit on VC1 while its counter is already full
    cycle(1'b0, '0, '0, 2'b10, "cred_ovf");
    check("cred_ovf.err", 32'(err_o), 32'd1);

    // Reset while VC0 holds two flits and a VC1 flit is on the output
    do_reset("reset4");
    for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(16'h7000 + i), 1'b0, 2'b00, "rs_fill");
    cycle(1'b1, 16'h7100, 1'b1, 2'b00, "rs_v1");
    idle("rs_v1_out");
    check("rs.pre_enable", 32'(enable_o), 32'd1);
    #2;
    valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rs.enable", 32'(enable_o), 32'd0);
    check("rs.data",   32'(data_o),   32'd0);
    check("rs.vc",     32'(vc_o),     32'd0);
    check("rs.credit", 32'(credit_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) idle("rs_quiet");
    cycle(1'b1, 16'h7200, 1'b0, 2'b00, "rs_new");
    idle("rs_new_out");
    check("rs.new_data", 32'(data_o), 32'h7200);

    // Randomized legal traffic against the model
    do_reset("reset5");
    for (int n = 0; n < 400; n++) begin
      logic              rv;
      logic [VC_W-1:0]   rc;
      logic [NUM_VC-1:0] rcr;
      rc = VC_W'($urandom_range(0, NUM_VC - 1));
      rv = ($urandom_range(0, 3) != 0) && (mq[rc].size() < DEPTH);
      for (int k = 0; k < NUM_VC; k++) begin
        rcr[k] = (m_dcred[k] < DOWN_CREDITS) && ($urandom_range(0, 2) == 0);
      end
      cycle(rv, DATA_W'($urandom), rc, rcr, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
